// File: rtl/nios_system_cursor_pio_mc.sv
// rtl/nios_system_cursor_pio_mc.sv - multi-channel tear-free cursor coordinate PIO
//
// Each channel holds a CPU-written SHADOW that is copied to the live output
// only on frame_strobe, so a coordinate pair never changes mid-frame. A channel
// can instead step itself by STEP on every strobe, clamped to [0, LIMIT].
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   address         {channel, reg[1:0]}; reg 0 SHADOW, 1 STEP, 2 LIMIT, 3 CTRL
//   chipselect      slave select; write when chipselect && !write_n
//   write_n         active-low write strobe
//   writedata       32-bit write data, bits above WIDTH ignored
//   readdata        combinational read data, unused bits 0
//   frame_strobe    one-cycle commit pulse
//   out_port        live values, channel c at [c*WIDTH +: WIDTH]
module nios_system_cursor_pio_mc #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 16,
  parameter int CH_W   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CH_W+1:0]           address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic                      frame_strobe,
  output logic [NUM_CH*WIDTH-1:0]   out_port
);

  logic [WIDTH-1:0] live_q   [NUM_CH];
  logic [WIDTH-1:0] shadow_q [NUM_CH];
  logic [WIDTH-1:0] step_q   [NUM_CH];
  logic [WIDTH-1:0] limit_q  [NUM_CH];
  logic [NUM_CH-1:0] auto_q, pend_q, clamp_q, lsel_q;

  logic [WIDTH-1:0] live_d    [NUM_CH];
  logic [WIDTH+1:0] sum       [NUM_CH];
  logic [NUM_CH-1:0] clamp_set;

  logic            wr_en;
  logic [CH_W-1:0] a_ch;
  logic [1:0]      a_reg;

  assign a_ch  = address[CH_W+1:2];
  assign a_reg = address[1:0];
  assign wr_en = chipselect & ~write_n;

  // Frame-strobe next-state for each channel, from pre-edge register values.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      // Two extra bits hold the full range of live + signed step; the top bit is the sign.
      sum[c]       = {2'b00, live_q[c]} + {{2{step_q[c][WIDTH-1]}}, step_q[c]};
      live_d[c]    = live_q[c];
      clamp_set[c] = 1'b0;
      if (frame_strobe) begin
        if (pend_q[c]) begin
          if (shadow_q[c] > limit_q[c]) begin
            live_d[c]    = limit_q[c];
            clamp_set[c] = 1'b1;
          end else begin
            live_d[c] = shadow_q[c];
          end
        end else if (auto_q[c]) begin
          if (sum[c][WIDTH+1]) begin
            live_d[c]    = '0;
            clamp_set[c] = 1'b1;
          end else if (sum[c] > {2'b00, limit_q[c]}) begin
            live_d[c]    = limit_q[c];
            clamp_set[c] = 1'b1;
          end else begin
            live_d[c] = sum[c][WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        live_q[c]   <= '0;
        shadow_q[c] <= '0;
        step_q[c]   <= '0;
        limit_q[c]  <= '1;
      end
      auto_q  <= '0;
      pend_q  <= '0;
      clamp_q <= '0;
      lsel_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        live_q[c] <= live_d[c];
        if (frame_strobe && pend_q[c]) pend_q[c] <= 1'b0;
        // Write follows the strobe update so a same-cycle SHADOW write re-arms PENDING.
        if (wr_en && (32'(a_ch) == c)) begin
          case (a_reg)
            2'd0: begin
              shadow_q[c] <= writedata[WIDTH-1:0];
              pend_q[c]   <= 1'b1;
            end
            2'd1: step_q[c]  <= writedata[WIDTH-1:0];
            2'd2: limit_q[c] <= writedata[WIDTH-1:0];
            2'd3: begin
              auto_q[c] <= writedata[0];
              lsel_q[c] <= writedata[3];
              if (writedata[2]) clamp_q[c] <= 1'b0;
            end
          endcase
        end
        // A fresh clamp wins over a same-cycle clear.
        if (clamp_set[c]) clamp_q[c] <= 1'b1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(a_ch) == c) begin
        case (a_reg)
          2'd0: readdata[WIDTH-1:0] = lsel_q[c] ? live_q[c] : shadow_q[c];
          2'd1: readdata[WIDTH-1:0] = step_q[c];
          2'd2: readdata[WIDTH-1:0] = limit_q[c];
          2'd3: readdata[3:0] = {lsel_q[c], clamp_q[c], pend_q[c], auto_q[c]};
        endcase
      end
    end
  end

  always_comb begin
    out_port = '0;
    for (int c = 0; c < NUM_CH; c++) out_port[c*WIDTH +: WIDTH] = live_q[c];
  end

endmodule

// File: tb/tb_nios_system_cursor_pio_mc.sv
// tb/tb_nios_system_cursor_pio_mc.sv - scoreboard bench for the cursor PIO
module tb_nios_system_cursor_pio_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        frame_strobe = 1'b0;
  logic [31:0] out_port;

  always #5 clk = ~clk;

  nios_system_cursor_pio_mc #(.NUM_CH(2), .WIDTH(16), .CH_W(2)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .frame_strobe(frame_strobe), .out_port(out_port)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] outq[$];
  logic [31:0] rdq[$];

  // Reference model: plain integers per channel.
  int m_live[2], m_sh[2], m_st[2], m_lim[2];
  bit m_auto[2], m_pend[2], m_clamp[2], m_lsel[2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_live[c] = 0; m_sh[c] = 0; m_st[c] = 0; m_lim[c] = 65535;
      m_auto[c] = 0; m_pend[c] = 0; m_clamp[c] = 0; m_lsel[c] = 0;
    end
  endfunction

  function automatic logic [31:0] m_out();
    logic [31:0] v;
    v[15:0]  = m_live[0][15:0];
    v[31:16] = m_live[1][15:0];
    return v;
  endfunction

  function automatic logic [31:0] m_read(int ch, int rg);
    if (ch >= 2) return 0;
    case (rg)
      0: return m_lsel[ch] ? m_live[ch] : m_sh[ch];
      1: return m_st[ch];
      2: return m_lim[ch];
      default: return (m_lsel[ch] ? 8 : 0) + (m_clamp[ch] ? 4 : 0) + (m_pend[ch] ? 2 : 0) + (m_auto[ch] ? 1 : 0);
    endcase
  endfunction

  function automatic void model_edge(bit rst, bit strb, bit wr, int ch, int rg, int d);
    bit cs[2];
    int s, dm;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      cs[c] = 0;
      if (strb) begin
        if (m_pend[c]) begin
          if (m_sh[c] > m_lim[c]) begin m_live[c] = m_lim[c]; cs[c] = 1; end
          else m_live[c] = m_sh[c];
          m_pend[c] = 0;
        end else if (m_auto[c]) begin
          s = m_live[c] + ((m_st[c] >= 32768) ? m_st[c] - 65536 : m_st[c]);
          if (s < 0) begin m_live[c] = 0; cs[c] = 1; end
          else if (s > m_lim[c]) begin m_live[c] = m_lim[c]; cs[c] = 1; end
          else m_live[c] = s;
        end
      end
    end
    dm = d & 32'hFFFF;
    if (wr && ch < 2) begin
      case (rg)
        0: begin m_sh[ch] = dm; m_pend[ch] = 1; end
        1: m_st[ch] = dm;
        2: m_lim[ch] = dm;
        default: begin
          m_auto[ch] = d[0];
          m_lsel[ch] = d[3];
          if (d[2]) m_clamp[ch] = 0;
        end
      endcase
    end
    for (int c = 0; c < 2; c++) if (cs[c]) m_clamp[c] = 1;
  endfunction

  task automatic cyc(bit rst, bit strb, bit wr, bit rd, int ch, int rg, int d);
    logic [31:0] dv;
    dv = d;
    @(posedge clk); #1;
    reset        = rst;
    frame_strobe = strb;
    chipselect   = wr | rd;
    write_n      = ~wr;
    address      = {ch[1:0], rg[1:0]};
    writedata    = dv;
    outq.push_back(m_out());
    if (rd) rdq.push_back(m_read(ch, rg));
    model_edge(rst, strb, wr, ch, rg, d);
  endtask

  task automatic wr(int ch, int rg, int d); cyc(0, 0, 1, 0, ch, rg, d); endtask
  task automatic rd(int ch, int rg); cyc(0, 0, 0, 1, ch, rg, 0); endtask
  task automatic stb(); cyc(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0); endtask

  // Monitor: compares DUT outputs against queued expectations mid-cycle.
  always @(negedge clk) begin
    if (outq.size() > 0) check("out_port", out_port, outq.pop_front());
    if (chipselect && write_n) begin
      if (rdq.size() > 0) check("readdata", readdata, rdq.pop_front());
      else check("readdata_unexpected", readdata, 32'hDEAD_BEEF);
    end
  end

  initial begin
    int rr, op, ch, rg, d;
    model_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // reset state, including unmapped channels 2 and 3
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) rd(c, r);

    // shadow held until strobe
    wr(0, 0, 32'h0140); rd(0, 3);
    stb(); idle(); @(negedge clk);
    check("t2_live", {16'h0, out_port[15:0]}, 32'h0140);
    rd(0, 3);

    // negative auto-step clamps at 0
    wr(1, 0, 3); stb();
    wr(1, 1, 32'hFFFE); wr(1, 3, 1);
    stb(); idle(); @(negedge clk); check("t3_a", {16'h0, out_port[31:16]}, 32'd1);
    stb(); idle(); @(negedge clk); check("t3_b", {16'h0, out_port[31:16]}, 32'd0);
    stb(); idle(); @(negedge clk); check("t3_c", {16'h0, out_port[31:16]}, 32'd0);
    rd(1, 3); wr(1, 3, 5); rd(1, 3);

    // positive auto-step clamps at LIMIT; oversize shadow clamps
    wr(0, 2, 639); wr(0, 0, 635); stb();
    wr(0, 1, 3); wr(0, 3, 1);
    stb(); idle(); @(negedge clk); check("t4_a", {16'h0, out_port[15:0]}, 32'd638);
    stb(); idle(); @(negedge clk); check("t4_b", {16'h0, out_port[15:0]}, 32'd639);
    rd(0, 3);
    wr(0, 0, 700); stb(); idle(); @(negedge clk);
    check("t4_c", {16'h0, out_port[15:0]}, 32'd639);

    // shadow write on the strobe cycle
    wr(0, 3, 4); wr(0, 0, 10);
    cyc(0, 1, 1, 0, 0, 0, 20); idle(); @(negedge clk);
    check("t5_a", {16'h0, out_port[15:0]}, 32'd10);
    rd(0, 3);
    stb(); idle(); @(negedge clk);
    check("t5_b", {16'h0, out_port[15:0]}, 32'd20);

    // LIVE_SEL read mux
    wr(0, 0, 99); wr(0, 3, 8); rd(0, 0); wr(0, 3, 0); rd(0, 0);

    // reset beats strobe with a pending commit
    cyc(1, 1, 0, 0, 0, 0, 0); idle(); @(negedge clk);
    check("t6_out", out_port, 32'h0);
    rd(0, 3); rd(0, 2); rd(1, 0);

    for (int i = 0; i < 600; i++) begin
      rr = $urandom_range(0, 99);
      op = $urandom_range(0, 2);
      ch = $urandom_range(0, 3);
      rg = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: d = $urandom_range(0, 700);
        1: d = $urandom;
        2: d = 32'hFFFF - $urandom_range(0, 5);
        default: d = $urandom_range(0, 15);
      endcase
      cyc(rr < 2, $urandom_range(0, 3) == 0, op == 0, op == 1, ch, rg, d);
    end

    idle(); idle(); idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
